// File: rtl/oled_spi_streamer_if.sv
// Byte-stream handshake between a producer and the OLED SPI streamer.
// Signals: in_valid/in_data/in_is_data (producer -> streamer), in_ready (streamer -> producer).
// master = producer side, slave = streamer side; a byte moves on a cycle with in_valid && in_ready.
interface oled_spi_streamer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_is_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_is_data, input in_ready);
    modport slave  (input in_valid, input in_data, input in_is_data, output in_ready);
endinterface

// File: rtl/oled_spi_streamer.sv
// Buffers command/data bytes in a FIFO and shifts them out to an SPI OLED panel (mode 0, MSB first),
// after running the panel reset/startup sequence. Ports: clk, rst (async, active high), in_if (byte
// stream, slave), sclk/sdin/cs/cmd/res panel pins, init_done, busy, fifo_level.
// Latency: a byte popped at edge P drives cs low from edge P; each frame holds cs low 17*CLK_DIV
// cycles followed by a CLK_DIV-cycle cs-high gap. Backpressure: in_ready drops when the FIFO is full.
module oled_spi_streamer #(
    parameter int CLK_DIV       = 4,
    parameter int RES_PULSE     = 100,
    parameter int STARTUP_DELAY = 1000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    oled_spi_streamer_if.slave            in_if,
    output logic                          sclk,
    output logic                          sdin,
    output logic                          res,
    output logic                          cmd,
    output logic                          cs,
    output logic                          init_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int M1   = (RES_PULSE > STARTUP_DELAY) ? RES_PULSE : STARTUP_DELAY;
    localparam int MAXC = (M1 > CLK_DIV) ? M1 : CLK_DIV;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] RES_LOW  = 3'd0;
    localparam logic [2:0] RES_WAIT = 3'd1;
    localparam logic [2:0] IDLE     = 3'd2;
    localparam logic [2:0] SHIFT    = 3'd3;
    localparam logic [2:0] CS_HOLD  = 3'd4;
    localparam logic [2:0] GAP      = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    half;      // sclk half-periods elapsed in the current byte
    logic [6:0]    sh;        // bits still to be presented on sdin
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [8:0]    head;
    logic          push, pop, cnt_done;

    assign in_if.in_ready = !rst && (fifo_level < (AW+1)'(FIFO_DEPTH));
    assign push     = in_if.in_valid && in_if.in_ready;
    assign cnt_done = (cnt == CW'(CLK_DIV - 1));
    // Pop straight from IDLE, or chain the next byte right at the end of the inter-frame gap.
    assign pop      = (fifo_level != '0) && ((state == IDLE) || ((state == GAP) && cnt_done));
    assign head     = mem[rptr];
    assign res      = (state != RES_LOW);
    assign busy     = (state != IDLE) || (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {in_if.in_is_data, in_if.in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RES_LOW;
            cnt       <= '0;
            half      <= '0;
            sh        <= '0;
            sclk      <= 1'b0;
            sdin      <= 1'b0;
            cmd       <= 1'b0;
            cs        <= 1'b1;
            init_done <= 1'b0;
        end else if (pop) begin
            state <= SHIFT;
            cnt   <= '0;
            half  <= '0;
            sh    <= head[6:0];
            sdin  <= head[7];
            cmd   <= head[8];
            cs    <= 1'b0;
            sclk  <= 1'b0;
        end else begin
            case (state)
                RES_LOW: begin
                    if (cnt == CW'(RES_PULSE - 1)) begin
                        state <= RES_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RES_WAIT: begin
                    if (cnt == CW'(STARTUP_DELAY - 1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    cnt <= '0;
                end
                SHIFT: begin
                    if (cnt_done) begin
                        cnt  <= '0;
                        sclk <= ~sclk;
                        half <= half + 1'b1;
                        // Falling edge: advance to the next bit, except after the last
                        // bit where sdin keeps its value into the hold/idle phase.
                        if (sclk) begin
                            if (half == 4'd15) begin
                                state <= CS_HOLD;
                            end else begin
                                sdin <= sh[6];
                                sh   <= {sh[5:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (cnt_done) begin
                        cs    <= 1'b1;
                        state <= GAP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RES_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_oled_spi_streamer.sv
// Bench for oled_spi_streamer with CLK_DIV=2, RES_PULSE=5, STARTUP_DELAY=10, FIFO_DEPTH=4.
// Accepted bytes push their expected frame onto a queue; an SPI decoder pops and compares per frame.
module tb_oled_spi_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oled_spi_streamer_if bus();
    logic sclk, sdin, res, cmd, cs, init_done, busy;
    logic [2:0] fifo_level;

    oled_spi_streamer #(.CLK_DIV(2), .RES_PULSE(5), .STARTUP_DELAY(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_if(bus),
        .sclk(sclk), .sdin(sdin), .res(res), .cmd(cmd), .cs(cs),
        .init_done(init_done), .busy(busy), .fifo_level(fifo_level)
    );

    typedef struct {
        logic       is_data;
        logic [7:0] data;
        logic       exp_cmd;
        logic [7:0] exp_bits;
    } vec_t;
    typedef struct {
        logic       cmd;
        logic [7:0] bits;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;
    int frames_started = 0;
    int frames_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SPI frame decoder, sampling on the falling clk edge.
    logic prev_cs = 1'b1, prev_sclk = 1'b0;
    logic in_frame = 1'b0, seen_end = 1'b0, f_cmd = 1'b0, cmd_changed = 1'b0;
    logic [7:0] bits = 8'h00;
    int low_len = 0, rises = 0, gap_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            seen_end = 1'b0;
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
        end else begin
            if (!cs && prev_cs) begin
                frames_started++;
                in_frame = 1'b1;
                low_len = 0;
                rises = 0;
                bits = 8'h00;
                f_cmd = cmd;
                cmd_changed = 1'b0;
                chk("cs_after_init", init_done, 1);
                if (seen_end) chk("gap_ge_2", (gap_len >= 2), 1);
            end
            if (!cs && in_frame) begin
                low_len++;
                if (sclk && !prev_sclk) begin
                    rises++;
                    bits = {bits[6:0], sdin};
                end
                if (cmd !== f_cmd) cmd_changed = 1'b1;
            end
            if (cs && !prev_cs && in_frame) begin
                in_frame = 1'b0;
                frames_done++;
                chk("frame_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("frame_cmd", f_cmd, mon_e.cmd);
                    chk("frame_bits", bits, mon_e.bits);
                    chk("frame_sclk_rises", rises, 8);
                    chk("frame_cs_low_cycles", low_len, 34);
                    chk("cmd_stable", cmd_changed, 0);
                end
                gap_len = 0;
                seen_end = 1'b1;
            end
            if (cs) gap_len++;
            prev_cs = cs;
            prev_sclk = sclk;
        end
    end

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic measure_startup(input string tag);
        int n = 0;
        int m = 0;
        while (n < 100) begin
            @(negedge clk);
            if (res) break;
            n++;
        end
        chk({tag, "_res_low_cycles"}, n, 5);
        while (m < 100) begin
            if (init_done) break;
            m++;
            @(negedge clk);
        end
        chk({tag, "_res_wait_cycles"}, m, 10);
        chk({tag, "_res_high"}, res, 1);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send(input logic d, input logic [7:0] b, input logic ec, input logic [7:0] eb);
        bit ok = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_is_data = d;
        bus.in_data = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                e.cmd = ec;
                e.bits = eb;
                sb.push_back(e);
                @(posedge clk);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", ok, 1);
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && cs && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_drained"}, ok, 1);
    endtask

    task automatic wait_res_high();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res) break;
        end
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int fs0, fd0;
        bit ok;
        vecs[0] = '{1'b0, 8'hAE, 1'b0, 8'b10101110};
        vecs[1] = '{1'b0, 8'h21, 1'b0, 8'b00100001};
        vecs[2] = '{1'b1, 8'hFF, 1'b1, 8'b11111111};
        vecs[3] = '{1'b1, 8'h00, 1'b1, 8'b00000000};
        vecs[4] = '{1'b1, 8'hA5, 1'b1, 8'b10100101};
        vecs[5] = '{1'b0, 8'h3C, 1'b0, 8'b00111100};

        // Reset state, with a producer already offering a byte.
        bus.in_valid = 1'b1;
        bus.in_is_data = 1'b1;
        bus.in_data = 8'h77;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdin", sdin, 0);
        chk("rst_res", res, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_cs", cs, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_fifo_level", fifo_level, 0);
        bus.in_valid = 1'b0;

        // Startup timing, then a single command byte, then the rest of the table back to back.
        release_rst();
        measure_startup("start");
        chk("idle_fifo_empty", fifo_level, 0);
        send(vecs[0].is_data, vecs[0].data, vecs[0].exp_cmd, vecs[0].exp_bits);
        drain("cmd_ae");
        chk("cmd_ae_frames", frames_done, 1);
        chk("idle_busy", busy, 0);
        for (int i = 1; i < 6; i++)
            send(vecs[i].is_data, vecs[i].data, vecs[i].exp_cmd, vecs[i].exp_bits);
        drain("table");
        chk("table_frames", frames_done, 6);

        // Bytes queued while the panel is still in its startup wait.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fd0 = frames_done;
        release_rst();
        wait_res_high();
        chk("preinit_in_res_wait", res, 1);
        send(1'b0, 8'h8D, 1'b0, 8'b10001101);
        send(1'b0, 8'h14, 1'b0, 8'b00010100);
        send(1'b1, 8'hC3, 1'b1, 8'b11000011);
        chk("preinit_level", fifo_level, 3);
        chk("preinit_cs_idle", cs, 1);
        chk("preinit_not_done", init_done, 0);
        drain("preinit");
        chk("preinit_frames", frames_done - fd0, 3);

        // Full FIFO during startup; the fifth byte must wait for the first pop.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fs0 = frames_started;
        fd0 = frames_done;
        release_rst();
        @(negedge clk);
        send(1'b1, 8'h01, 1'b1, 8'b00000001);
        send(1'b1, 8'h02, 1'b1, 8'b00000010);
        send(1'b0, 8'h80, 1'b0, 8'b10000000);
        send(1'b1, 8'h7E, 1'b1, 8'b01111110);
        chk("full_level", fifo_level, 4);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_before_init", init_done, 0);
        send(1'b0, 8'hE7, 1'b0, 8'b11100111);
        chk("fifth_after_first_pop", frames_started - fs0, 1);
        chk("fifth_cs_low", cs, 0);
        drain("full");
        chk("full_frames", frames_done - fd0, 5);

        // Reset in the middle of a byte.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();
        wait_res_high();
        send(1'b1, 8'h81, 1'b1, 8'b10000001);
        send(1'b1, 8'h42, 1'b1, 8'b01000010);
        send(1'b0, 8'h99, 1'b0, 8'b10011001);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!cs) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_frame_started", ok, 1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_cs", cs, 1);
        chk("abort_fifo_level", fifo_level, 0);
        chk("abort_res", res, 0);
        chk("abort_sclk", sclk, 0);
        chk("abort_init_done", init_done, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        fs0 = frames_started;
        release_rst();
        measure_startup("rerun");
        repeat (60) @(negedge clk);
        chk("rerun_no_frames", frames_started - fs0, 0);
        chk("rerun_fifo_empty", fifo_level, 0);
        fd0 = frames_done;
        send(1'b1, 8'h5A, 1'b1, 8'b01011010);
        drain("rerun");
        chk("rerun_frames", frames_done - fd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
